// File: rtl/emif_rst_cal_csr.sv
// DFH-compliant CSR slave plus a per-channel memory reset pulse / calibration-wait sequencer.
// Each channel pulses mem_rst, waits for calibration with a timeout, and records sticky fail/timeout status.
module emif_rst_cal_csr #(
   parameter int          NUM_CH          = 4,
   parameter int unsigned CAL_TIMEOUT     = 1024,
   parameter int          RST_PULSE_CYC   = 16,
   parameter logic [11:0] FEAT_ID         = 12'h009,
   parameter logic [3:0]  MAJOR_VER       = 4'h1,
   parameter logic [3:0]  MINOR_VER       = 4'h0,
   parameter logic [23:0] NEXT_DFH_OFFSET = 24'h00B000,
   parameter logic        END_OF_LIST     = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csr_wr,
   input  logic              csr_rd,
   input  logic [7:0]        csr_addr,
   input  logic [63:0]       csr_wdata,
   output logic [63:0]       csr_rdata,
   output logic              csr_rvalid,
   input  logic [NUM_CH-1:0] cal_success,
   input  logic [NUM_CH-1:0] cal_fail,
   output logic [NUM_CH-1:0] mem_rst,
   output logic [NUM_CH-1:0] mem_ready
);

   localparam logic [2:0] ST_RESET    = 3'd0;
   localparam logic [2:0] ST_WAIT_CAL = 3'd1;
   localparam logic [2:0] ST_READY    = 3'd2;
   localparam logic [2:0] ST_FAIL     = 3'd3;
   localparam logic [2:0] ST_TIMEOUT  = 3'd4;

   localparam logic [31:0] RST_LAST = 32'(RST_PULSE_CYC - 1);
   localparam logic [31:0] CAL_LAST = 32'(CAL_TIMEOUT - 1);
   localparam logic [63:0] DFH_VAL  = {4'h3, 8'h00, MINOR_VER, 7'h00, END_OF_LIST,
                                       NEXT_DFH_OFFSET, MAJOR_VER, FEAT_ID};
   localparam logic [63:0] CAP_VAL  = {32'(CAL_TIMEOUT), 16'(RST_PULSE_CYC), 8'(NUM_CH),
                                       8'((1 << NUM_CH) - 1)};

   logic [4:0]        reg_sel;
   logic              wr_status;
   logic              wr_ctrl;
   logic              wr_scratch;
   logic [NUM_CH-1:0] restart;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] fail_set;
   logic [NUM_CH-1:0] to_set;
   logic [NUM_CH-1:0] fail_clr;
   logic [NUM_CH-1:0] to_clr;
   logic [NUM_CH-1:0] fail_sticky;
   logic [NUM_CH-1:0] to_sticky;
   logic [63:0]       scratch;
   logic [63:0]       rd_mux;
   logic              unused_addr_lsb;

   // Registers are 64-bit aligned; the byte-offset bits carry no meaning.
   assign reg_sel         = csr_addr[7:3];
   assign unused_addr_lsb = ^csr_addr[2:0];

   assign wr_status  = csr_wr && (reg_sel == 5'd1);
   assign wr_ctrl    = csr_wr && (reg_sel == 5'd3);
   assign wr_scratch = csr_wr && (reg_sel == 5'd4);
   assign restart    = wr_ctrl   ? csr_wdata[NUM_CH-1:0]  : '0;
   assign fail_clr   = wr_status ? csr_wdata[8 +: NUM_CH]  : '0;
   assign to_clr     = wr_status ? csr_wdata[16 +: NUM_CH] : '0;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [2:0]  state;
      logic [31:0] cnt;

      always_ff @(posedge clk) begin
         if (rst || restart[g]) begin
            state <= ST_RESET;
            cnt   <= '0;
         end else begin
            case (state)
               ST_RESET: begin
                  if (cnt == RST_LAST) begin
                     state <= ST_WAIT_CAL;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               ST_WAIT_CAL: begin
                  cnt <= cnt + 32'd1;
                  if (cal_fail[g])            state <= ST_FAIL;
                  else if (cal_success[g])    state <= ST_READY;
                  else if (cnt == CAL_LAST)   state <= ST_TIMEOUT;
               end
               ST_READY: begin
                  if (cal_fail[g] || !cal_success[g]) state <= ST_FAIL;
               end
               default: ;
            endcase
         end
      end

      assign mem_rst[g]   = (state == ST_RESET);
      assign mem_ready[g] = (state == ST_READY);
      assign busy[g]      = (state == ST_RESET) || (state == ST_WAIT_CAL);

      // A restart pre-empts any event the channel would otherwise record this cycle.
      assign fail_set[g] = !restart[g] &&
                           (((state == ST_WAIT_CAL) && cal_fail[g]) ||
                            ((state == ST_READY) && (cal_fail[g] || !cal_success[g])));
      assign to_set[g]   = !restart[g] && (state == ST_WAIT_CAL) && !cal_fail[g] &&
                           !cal_success[g] && (cnt == CAL_LAST);
   end

   // Set events take priority over a same-cycle write-one-to-clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         fail_sticky <= '0;
         to_sticky   <= '0;
         scratch     <= '0;
      end else begin
         fail_sticky <= (fail_sticky & ~fail_clr) | fail_set;
         to_sticky   <= (to_sticky & ~to_clr) | to_set;
         if (wr_scratch) scratch <= csr_wdata;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         5'd0: rd_mux = DFH_VAL;
         5'd1: begin
            rd_mux[NUM_CH-1:0]   = mem_ready;
            rd_mux[8 +: NUM_CH]  = fail_sticky;
            rd_mux[16 +: NUM_CH] = to_sticky;
            rd_mux[24 +: NUM_CH] = busy;
         end
         5'd2:    rd_mux = CAP_VAL;
         5'd4:    rd_mux = scratch;
         default: rd_mux = '0;
      endcase
   end

   // Read data is captured from pre-write register values and held until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_rvalid <= 1'b0;
         csr_rdata  <= '0;
      end else begin
         csr_rvalid <= csr_rd;
         if (csr_rd) csr_rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_emif_rst_cal_csr.sv
// Self-checking bench for emif_rst_cal_csr: directed scenarios plus randomized traffic
// checked against a timestamp-based channel model.
module tb_emif_rst_cal_csr;

   localparam int P_PULSE = 16;
   localparam int P_TO    = 1024;
   localparam int OUT_NONE = 0, OUT_READY = 1, OUT_FAIL = 2, OUT_TIMEOUT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csr_wr = 1'b0;
   logic        csr_rd = 1'b0;
   logic [7:0]  csr_addr = 8'h00;
   logic [63:0] csr_wdata = 64'h0;
   logic [63:0] csr_rdata;
   logic        csr_rvalid;
   logic [3:0]  cal_success = 4'h0;
   logic [3:0]  cal_fail = 4'h0;
   logic [3:0]  mem_rst;
   logic [3:0]  mem_ready;

   int n_checks = 0;
   int n_fail   = 0;

   emif_rst_cal_csr dut (
      .clk         (clk),
      .rst         (rst),
      .csr_wr      (csr_wr),
      .csr_rd      (csr_rd),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .csr_rvalid  (csr_rvalid),
      .cal_success (cal_success),
      .cal_fail    (cal_fail),
      .mem_rst     (mem_rst),
      .mem_ready   (mem_ready)
   );

   always #5 clk = ~clk;

   // Reference model: each channel remembers when its reset pulse started and how it settled.
   int          cyc = 0;
   int          m_start [4];
   int          m_out   [4];
   logic [3:0]  m_fail = 4'h0;
   logic [3:0]  m_to = 4'h0;
   logic [63:0] m_scratch = 64'h0;
   logic [63:0] m_rdata = 64'h0;
   logic        m_rvalid = 1'b0;

   function automatic logic [3:0] exp_rst();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (m_out[i] == OUT_NONE) && ((cyc - m_start[i]) < P_PULSE);
      return r;
   endfunction

   function automatic logic [3:0] exp_ready();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (m_out[i] == OUT_READY);
      return r;
   endfunction

   function automatic logic [63:0] m_read(input logic [7:0] a);
      logic [63:0] s;
      s = 64'h0;
      case (a & 8'hF8)
         8'h00: s = 64'h3000_0000_B000_1009;
         8'h08: begin
            for (int i = 0; i < 4; i++) begin
               s[i]      = (m_out[i] == OUT_READY);
               s[8 + i]  = m_fail[i];
               s[16 + i] = m_to[i];
               s[24 + i] = (m_out[i] == OUT_NONE);
            end
         end
         8'h10: s = 64'h0000_0400_0010_040F;
         8'h20: s = m_scratch;
         default: s = 64'h0;
      endcase
      return s;
   endfunction

   always @(posedge clk) begin : model
      logic [3:0]  fs;
      logic [3:0]  ts;
      logic [63:0] rv;
      int          age;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_start[i] = cyc + 1;
            m_out[i]   = OUT_NONE;
         end
         m_fail = 4'h0; m_to = 4'h0; m_scratch = 64'h0; m_rdata = 64'h0; m_rvalid = 1'b0;
      end else begin
         rv = m_read(csr_addr);
         if (csr_rd) m_rdata = rv;
         m_rvalid = csr_rd;
         fs = 4'h0;
         ts = 4'h0;
         for (int i = 0; i < 4; i++) begin
            age = cyc - m_start[i];
            if (csr_wr && ((csr_addr & 8'hF8) == 8'h18) && csr_wdata[i]) begin
               m_start[i] = cyc + 1;
               m_out[i]   = OUT_NONE;
            end else if (m_out[i] == OUT_NONE && age >= P_PULSE) begin
               if (cal_fail[i]) begin
                  m_out[i] = OUT_FAIL; fs[i] = 1'b1;
               end else if (cal_success[i]) begin
                  m_out[i] = OUT_READY;
               end else if (age - P_PULSE == P_TO - 1) begin
                  m_out[i] = OUT_TIMEOUT; ts[i] = 1'b1;
               end
            end else if (m_out[i] == OUT_READY && (cal_fail[i] || !cal_success[i])) begin
               m_out[i] = OUT_FAIL; fs[i] = 1'b1;
            end
         end
         if (csr_wr && ((csr_addr & 8'hF8) == 8'h08)) begin
            m_fail = m_fail & ~csr_wdata[11:8];
            m_to   = m_to & ~csr_wdata[19:16];
         end
         m_fail = m_fail | fs;
         m_to   = m_to | ts;
         if (csr_wr && ((csr_addr & 8'hF8) == 8'h20)) m_scratch = csr_wdata;
      end
      cyc = cyc + 1;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic csr_read(input logic [7:0] a, output logic [63:0] d, output logic v);
      csr_rd = 1'b1;
      csr_addr = a;
      tick();
      csr_rd = 1'b0;
      d = csr_rdata;
      v = csr_rvalid;
   endtask

   task automatic csr_write(input logic [7:0] a, input logic [63:0] d);
      csr_wr = 1'b1;
      csr_addr = a;
      csr_wdata = d;
      tick();
      csr_wr = 1'b0;
   endtask

   // Counts cycles the given channel's mem_rst stays high, starting from the current cycle.
   task automatic pulse_len(input int ch, output int n);
      n = 0;
      while (mem_rst[ch] && n < 64) begin
         n++;
         tick();
      end
   endtask

   // Reads STATUS back-to-back from now; k is the index of the first read with the bit set.
   task automatic poll_status_bit(input int bitn, output int k);
      logic found;
      found = 1'b0;
      k = 0;
      csr_rd = 1'b1;
      csr_addr = 8'h08;
      while (!found && k < 1200) begin
         tick();
         if (csr_rdata[bitn]) found = 1'b1;
         else k++;
      end
      csr_rd = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic v;
      do_reset();
      csr_read(8'h00, d, v);
      rst = 1'b1;
      csr_rd = 1'b1;
      tick();
      csr_rd = 1'b0;
      n_checks++; if (mem_rst !== 4'hF) begin n_fail++; $display("FAIL rst_mem_rst: got %h expected f", mem_rst); end
      n_checks++; if (mem_ready !== 4'h0) begin n_fail++; $display("FAIL rst_mem_ready: got %h expected 0", mem_ready); end
      n_checks++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 0", csr_rvalid); end
      n_checks++; if (csr_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", csr_rdata); end
      tick();
      rst = 1'b0;
      csr_read(8'h08, d, v);
      n_checks++; if (d !== 64'h0F00_0000) begin n_fail++; $display("FAIL rst_status: got %h expected 0f000000", d); end
      csr_read(8'h00, d, v);
      n_checks++; if (d !== 64'h3000_0000_B000_1009 || v !== 1'b1) begin n_fail++; $display("FAIL dfh_read: got %h v=%b expected 3000_0000_b000_1009 v=1", d, v); end
      csr_read(8'h10, d, v);
      n_checks++; if (d !== 64'h0000_0400_0010_040F) begin n_fail++; $display("FAIL cap_read: got %h expected 0000_0400_0010_040f", d); end
   endtask

   task automatic test_bringup();
      logic [63:0] d;
      logic v;
      int n;
      cal_success = 4'h0;
      cal_fail = 4'h0;
      do_reset();
      pulse_len(0, n);
      n_checks++; if (n !== P_PULSE) begin n_fail++; $display("FAIL bringup_pulse: got %0d cycles expected %0d", n, P_PULSE); end
      n_checks++; if (mem_rst !== 4'h0) begin n_fail++; $display("FAIL bringup_all_released: got %h expected 0", mem_rst); end
      repeat (5) tick();
      cal_success = 4'hF;
      tick();
      n_checks++; if (mem_ready !== 4'hF) begin n_fail++; $display("FAIL bringup_ready: got %h expected f", mem_ready); end
      csr_read(8'h08, d, v);
      n_checks++; if (d !== 64'h0000_000F) begin n_fail++; $display("FAIL bringup_status: got %h expected f", d); end
   endtask

   task automatic test_timeout();
      logic [63:0] d;
      logic v;
      int n;
      int k;
      cal_success = 4'b1011;
      cal_fail = 4'h0;
      do_reset();
      pulse_len(2, n);
      poll_status_bit(18, k);
      n_checks++; if (k !== P_TO) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected %0d", k, P_TO); end
      n_checks++; if (mem_ready !== 4'b1011) begin n_fail++; $display("FAIL timeout_ready: got %h expected b", mem_ready); end
      csr_write(8'h08, 64'h1 << 18);
      csr_read(8'h08, d, v);
      n_checks++; if (d[18] !== 1'b0 || d !== m_rdata) begin n_fail++; $display("FAIL timeout_w1c: got %h expected %h", d, m_rdata); end
      csr_write(8'h18, 64'h4);
      n_checks++; if (mem_rst !== 4'h4) begin n_fail++; $display("FAIL restart_ch2_rst: got %h expected 4", mem_rst); end
      pulse_len(2, n);
      n_checks++; if (n !== P_PULSE) begin n_fail++; $display("FAIL restart_ch2_pulse: got %0d cycles expected %0d", n, P_PULSE); end
   endtask

   task automatic test_simultaneous();
      logic [63:0] d;
      logic v;
      int n;
      csr_read(8'h08, d, v);
      n_checks++; if (d[9] !== 1'b0) begin n_fail++; $display("FAIL simul_bit9_pre: got %b expected 0", d[9]); end
      csr_write(8'h18, 64'h2);
      cal_success[1] = 1'b0;
      pulse_len(1, n);
      cal_success[1] = 1'b1;
      cal_fail[1] = 1'b1;
      tick();
      cal_success[1] = 1'b0;
      cal_fail[1] = 1'b0;
      n_checks++; if (mem_ready[1] !== 1'b0) begin n_fail++; $display("FAIL simul_ready1: got %b expected 0", mem_ready[1]); end
      csr_read(8'h08, d, v);
      n_checks++; if (d[9] !== 1'b1 || d[25] !== 1'b0 || d !== m_rdata) begin n_fail++; $display("FAIL simul_fail_wins: got %h expected %h", d, m_rdata); end
      csr_write(8'h18, 64'h2);
      pulse_len(1, n);
      csr_read(8'h08, d, v);
      n_checks++; if (d[9] !== 1'b1) begin n_fail++; $display("FAIL restart_keeps_sticky: got %b expected 1", d[9]); end
      cal_fail[1] = 1'b1;
      csr_write(8'h08, 64'h1 << 9);
      cal_fail[1] = 1'b0;
      csr_read(8'h08, d, v);
      n_checks++; if (d[9] !== 1'b1) begin n_fail++; $display("FAIL w1c_vs_set: got %b expected 1", d[9]); end
      csr_write(8'h08, 64'h1 << 9);
      csr_read(8'h08, d, v);
      n_checks++; if (d[9] !== 1'b0) begin n_fail++; $display("FAIL w1c_alone: got %b expected 0", d[9]); end
   endtask

   task automatic test_restart_mid();
      int n;
      int k;
      cal_success[0] = 1'b0;
      csr_write(8'h18, 64'h1);
      pulse_len(0, n);
      repeat (500) tick();
      csr_write(8'h18, 64'h1);
      n_checks++; if (mem_rst[0] !== 1'b1) begin n_fail++; $display("FAIL mid_restart_rst: got %b expected 1", mem_rst[0]); end
      pulse_len(0, n);
      n_checks++; if (n !== P_PULSE) begin n_fail++; $display("FAIL mid_restart_pulse: got %0d cycles expected %0d", n, P_PULSE); end
      poll_status_bit(16, k);
      n_checks++; if (k !== P_TO) begin n_fail++; $display("FAIL mid_restart_window: got %0d cycles expected %0d", k, P_TO); end
   endtask

   task automatic test_csr_misc();
      logic [63:0] d;
      logic v;
      csr_wr = 1'b1;
      csr_rd = 1'b1;
      csr_addr = 8'h20;
      csr_wdata = 64'hDEAD_BEEF_0123_4567;
      tick();
      csr_wr = 1'b0;
      csr_rd = 1'b0;
      n_checks++; if (csr_rdata !== 64'h0) begin n_fail++; $display("FAIL scratch_same_cycle: got %h expected 0", csr_rdata); end
      csr_read(8'h20, d, v);
      n_checks++; if (d !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL scratch_read: got %h expected deadbeef01234567", d); end
      tick();
      n_checks++; if (csr_rvalid !== 1'b0 || csr_rdata !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL rdata_hold: got %h v=%b expected deadbeef01234567 v=0", csr_rdata, csr_rvalid); end
      csr_read(8'h27, d, v);
      n_checks++; if (d !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL addr_lsb_ignored: got %h expected deadbeef01234567", d); end
      csr_read(8'h30, d, v);
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
      csr_read(8'h18, d, v);
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL ctrl_read: got %h expected 0", d); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         cal_success = 4'($urandom) | 4'($urandom);
         cal_fail    = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         csr_rd      = 1'($urandom);
         csr_wr      = ($urandom_range(0, 3) == 0);
         csr_addr    = 8'($urandom_range(0, 63));
         csr_wdata   = {$urandom, $urandom};
         tick();
         n_checks++; if (mem_rst !== exp_rst()) begin n_fail++; $display("FAIL rand_mem_rst c=%0d: got %h expected %h", c, mem_rst, exp_rst()); end
         n_checks++; if (mem_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_mem_ready c=%0d: got %h expected %h", c, mem_ready, exp_ready()); end
         n_checks++; if (csr_rvalid !== m_rvalid || csr_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_read c=%0d: got %h v=%b expected %h v=%b", c, csr_rdata, csr_rvalid, m_rdata, m_rvalid); end
      end
      csr_rd = 1'b0;
      csr_wr = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_bringup();
      test_timeout();
      test_simultaneous();
      test_restart_mid();
      test_csr_misc();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
